// File: rtl/rotate_sequencer_if.sv
// Command channel between the user control logic and the rotate sequencer:
// a valid/ready handshake carrying op/count/data, plus the abort request.
interface rotate_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        output cmd_data,
        output abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        input  cmd_data,
        input  abort,
        output cmd_ready
    );
endinterface

// File: rtl/rotate_sequencer.sv
// Sequences load / rotate / arithmetic-shift commands onto the control lines of
// an 8-bit shift-register datapath, one step per clock, with a done pulse.
module rotate_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    rotate_sequencer_if.slave cmd,
    output logic             reg_en,
    output logic             reg_load_n,
    output logic             reg_dir_right,
    output logic             reg_asr,
    output logic [WIDTH-1:0] reg_data,
    output logic             busy,
    output logic             done,
    output logic             aborted
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] rem_q;
    logic             aborted_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            data_q    <= '0;
            rem_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    aborted_q <= 1'b0;
                    if (cmd.cmd_valid) begin
                        op_q   <= cmd.cmd_op;
                        data_q <= cmd.cmd_data;
                        rem_q  <= cmd.cmd_count;
                        if (cmd.cmd_op == 2'b00) begin
                            state_q <= S_LOAD;
                        end else if (cmd.cmd_count == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_LOAD: begin
                    state_q <= S_DONE;
                end
                S_SHIFT: begin
                    // Abort wins over the step: nothing moves in the abort cycle.
                    if (cmd.abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    aborted_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded from registered state; reset low forces the quiet values at once.
    assign cmd.cmd_ready = reset && (state_q == S_IDLE);

    always_comb begin
        reg_en        = 1'b0;
        reg_load_n    = 1'b1;
        reg_dir_right = 1'b0;
        reg_asr       = 1'b0;
        reg_data      = '0;
        busy          = 1'b0;
        done          = 1'b0;
        aborted       = 1'b0;
        if (reset) begin
            reg_data = data_q;
            busy     = (state_q != S_IDLE);
            done     = (state_q == S_DONE);
            aborted  = (state_q == S_DONE) && aborted_q;
            case (state_q)
                S_LOAD: begin
                    reg_en     = 1'b1;
                    reg_load_n = 1'b0;
                end
                S_SHIFT: begin
                    reg_en        = !cmd.abort;
                    reg_dir_right = op_q[1];
                    reg_asr       = (op_q == 2'b11);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench: directed vector table, hand-written reset/abort sequences,
// and random commands checked against an arithmetic reference of the register.
module tb_rotate_sequencer;
    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             reg_en, reg_load_n, reg_dir_right, reg_asr;
    logic [WIDTH-1:0] reg_data;
    logic             busy, done, aborted;

    int n_cmp = 0;
    int n_bad = 0;

    rotate_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cif ();

    rotate_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cif.slave),
        .reg_en       (reg_en),
        .reg_load_n   (reg_load_n),
        .reg_dir_right(reg_dir_right),
        .reg_asr      (reg_asr),
        .reg_data     (reg_data),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    // Datapath model driven by the sequencer's control lines (sampled mid-cycle).
    logic [7:0] model = 8'h00;
    logic       s_en = 1'b0, s_load_n = 1'b1, s_dir = 1'b0, s_asr = 1'b0;
    logic [7:0] s_data = 8'h00;

    always @(negedge clk) begin
        s_en     = reg_en;
        s_load_n = reg_load_n;
        s_dir    = reg_dir_right;
        s_asr    = reg_asr;
        s_data   = reg_data;
    end

    always @(posedge clk) begin
        if (s_en === 1'b1) begin
            if (!s_load_n)  model = s_data;
            else if (s_dir) model = s_asr ? {model[7], model[7:1]} : {model[0], model[7:1]};
            else            model = {model[6:0], model[7]};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Whole-command result computed with plain arithmetic.
    function automatic logic [7:0] ref_apply(input logic [7:0] v, input logic [1:0] op, input int n);
        logic [15:0]       w;
        logic signed [7:0] s;
        s = v;
        case (op)
            2'd1: begin w = {v, v} << n; return w[15:8]; end
            2'd2: begin w = {v, v} >> n; return w[7:0]; end
            2'd3: return s >>> n;
            default: return v;
        endcase
    endfunction

    // Called just after a rising edge with the DUT idle; returns just after the
    // edge that ends the DONE cycle.
    task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [7:0] data,
                           input int abort_at, input int exp_en, input int exp_done,
                           input logic [7:0] exp_model, input bit exp_ab, input bit noise);
        int  en_cnt;
        int  done_cyc;
        bit  ab;
        bit  in_shift;
        en_cnt   = 0;
        done_cyc = 0;
        ab       = 1'b0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_count = CNT_W'(cnt);
        cif.cmd_data  = data;
        cif.abort     = 1'b0;
        @(negedge clk);
        chk("ready_in_idle", cif.cmd_ready, 1);
        chk("done_low_in_idle", done, 0);
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            cif.abort = (k == abort_at);
            if (noise) begin
                cif.cmd_valid = 1'($urandom);
                cif.cmd_op    = 2'($urandom);
                cif.cmd_count = CNT_W'($urandom);
                cif.cmd_data  = 8'($urandom);
            end else begin
                cif.cmd_valid = 1'b0;
            end
            @(negedge clk);
            in_shift = (op != 2'd0) && (cnt != 0) && (k < exp_done);
            chk("ready_while_busy", cif.cmd_ready, 0);
            chk("busy", busy, 1);
            chk("dir_right", reg_dir_right, in_shift && op[1]);
            chk("asr", reg_asr, in_shift && (op == 2'd3));
            if (reg_en === 1'b1) en_cnt++;
            if (done === 1'b1) begin
                done_cyc = k;
                ab       = aborted;
                break;
            end
            @(posedge clk); #1;
        end
        cif.abort = 1'b0;
        chk("step_count", en_cnt, exp_en);
        chk("done_cycle", done_cyc, exp_done);
        chk("aborted", ab, exp_ab);
        chk("model", model, exp_model);
        chk("reg_data", reg_data, data);
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        $display("cmd op=%0d cnt=%0d data=%02h abort_at=%0d steps=%0d done@%0d aborted=%0d model=%02h",
                 op, cnt, data, abort_at, en_cnt, done_cyc, ab, model);
    endtask

    typedef struct {
        logic [1:0] op;
        int         cnt;
        logic [7:0] data;
        int         abort_at;
        int         exp_en;
        int         exp_done;
        logic [7:0] exp_model;
        bit         exp_ab;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [1:0] op;
        int         cnt, abort_at, steps, exp_en, exp_done;
        logic [7:0] data, ref_v;

        tbl[0]  = '{2'd0, 0, 8'h96, -1, 1, 2, 8'h96, 1'b0};
        tbl[1]  = '{2'd2, 3, 8'h3C, -1, 3, 4, 8'hD2, 1'b0};
        tbl[2]  = '{2'd0, 0, 8'h96, -1, 1, 2, 8'h96, 1'b0};
        tbl[3]  = '{2'd3, 2, 8'h11, -1, 2, 3, 8'hE5, 1'b0};
        tbl[4]  = '{2'd0, 0, 8'h96, -1, 1, 2, 8'h96, 1'b0};
        tbl[5]  = '{2'd3, 1, 8'h22, -1, 1, 2, 8'hCB, 1'b0};
        tbl[6]  = '{2'd0, 0, 8'h81, -1, 1, 2, 8'h81, 1'b0};
        tbl[7]  = '{2'd1, 5, 8'h33, -1, 5, 6, 8'h30, 1'b0};
        tbl[8]  = '{2'd1, 0, 8'h44, -1, 0, 1, 8'h30, 1'b0};
        tbl[9]  = '{2'd0, 0, 8'h01, -1, 1, 2, 8'h01, 1'b0};
        tbl[10] = '{2'd2, 7, 8'h55,  3, 2, 4, 8'h40, 1'b1};
        tbl[11] = '{2'd0, 0, 8'h01, -1, 1, 2, 8'h01, 1'b0};
        tbl[12] = '{2'd1, 7, 8'h66, -1, 7, 8, 8'h80, 1'b0};
        tbl[13] = '{2'd3, 0, 8'h77, -1, 0, 1, 8'h80, 1'b0};

        // Reset held with a command offered: nothing may be accepted.
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'd0;
        cif.cmd_count = '0;
        cif.cmd_data  = 8'hFF;
        cif.abort     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", cif.cmd_ready, 0);
            chk("rst_reg_en", reg_en, 0);
            chk("rst_load_n", reg_load_n, 1);
            chk("rst_busy", busy, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cif.cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_data", reg_data, 8'h00);
        $display("reset released: ready=%0d busy=%0d", cif.cmd_ready, busy);
        @(posedge clk); #1;

        foreach (tbl[i])
            run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].abort_at, tbl[i].exp_en,
                    tbl[i].exp_done, tbl[i].exp_model, tbl[i].exp_ab, 1'(i % 2));

        // Random commands against the arithmetic reference.
        ref_v = tbl[13].exp_model;
        for (int t = 0; t < 60; t++) begin
            op       = 2'($urandom_range(0, 3));
            cnt      = $urandom_range(0, 7);
            data     = 8'($urandom);
            abort_at = -1;
            if (op != 2'd0 && cnt > 0 && $urandom_range(0, 3) == 0)
                abort_at = $urandom_range(1, cnt);
            steps = (abort_at > 0) ? abort_at - 1 : cnt;
            if (op == 2'd0) begin
                exp_en   = 1;
                exp_done = 2;
                ref_v    = data;
            end else begin
                exp_en   = steps;
                exp_done = (cnt == 0) ? 1 : steps + 2 - ((abort_at > 0) ? 0 : 1);
                ref_v    = ref_apply(ref_v, op, steps);
            end
            run_cmd(op, cnt, data, abort_at, exp_en, exp_done, ref_v, abort_at > 0, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset pulled low in cycle 2 of a 5-step rotate left.
        run_cmd(2'd0, 0, 8'h81, -1, 1, 2, 8'h81, 1'b0, 1'b0);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'd1;
        cif.cmd_count = CNT_W'(5);
        cif.cmd_data  = 8'h00;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_step1", reg_en, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_reg_en", reg_en, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("after_rst_reg_en", reg_en, 0);
            chk("after_rst_done", done, 0);
            chk("after_rst_ready", cif.cmd_ready, 1);
        end
        chk("after_rst_model", model, 8'h03);
        $display("mid-command reset: model=%02h ready=%0d", model, cif.cmd_ready);
        @(posedge clk); #1;
        run_cmd(2'd0, 0, 8'h5A, -1, 1, 2, 8'h5A, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
